// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: command opcodes,
// FSM state encoding and a small opcode classification helper.
package usr_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_LOAD = 3'd1;
    localparam logic [2:0] OP_LSL  = 3'd2;
    localparam logic [2:0] OP_LSR  = 3'd3;
    localparam logic [2:0] OP_ASR  = 3'd4;
    localparam logic [2:0] OP_ROL  = 3'd5;
    localparam logic [2:0] OP_ROR  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } usr_state_t;

    // True for the five ops that advance bit by bit; reserved op 7 is not one.
    function automatic logic is_shift_op(input logic [2:0] op);
        logic res;
        case (op)
            OP_LSL, OP_LSR, OP_ASR, OP_ROL, OP_ROR: res = 1'b1;
            default:                                res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit step of the universal shift register: given the
// current contents and op, produce the next contents and the bit pushed out.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] data,
    input  logic [2:0]   op,
    input  logic         serial_in,
    output logic [N-1:0] next_data,
    output logic         out_bit
);

    // One-bit shift/rotate selected by op; non-shift ops pass data through.
    always_comb begin
        next_data = data;
        out_bit   = 1'b0;
        case (op)
            OP_LSL: begin
                next_data = {data[N-2:0], serial_in};
                out_bit   = data[N-1];
            end
            OP_LSR: begin
                next_data = {serial_in, data[N-1:1]};
                out_bit   = data[0];
            end
            OP_ASR: begin
                next_data = {data[N-1], data[N-1:1]};
                out_bit   = data[0];
            end
            OP_ROL: begin
                next_data = {data[N-2:0], data[N-1]};
                out_bit   = data[N-1];
            end
            OP_ROR: begin
                next_data = {data[0], data[N-1:1]};
                out_bit   = data[0];
            end
            default: begin
                next_data = data;
                out_bit   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_register.sv
// Command-driven N-bit universal shift register: accepts one command via
// valid/ready, shifts one bit per clock and pulses done on completion.
module universal_shift_register
    import usr_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [2:0]           cmd_op,
    input  logic [$clog2(N)-1:0] cmd_amt,
    input  logic [N-1:0]         load_data,
    input  logic                 serial_in,
    output logic [N-1:0]         data_out,
    output logic                 serial_out,
    output logic                 busy,
    output logic                 done
);

    localparam int AMT_W = $clog2(N);

    usr_state_t       state_r;
    logic [2:0]       op_r;
    logic [AMT_W-1:0] count_r;
    logic [N-1:0]     data_r;
    logic             serial_r;
    logic             done_r;
    logic [N-1:0]     step_data_s;
    logic             step_out_s;

    usr_shift_step #(.N(N)) u_step (
        .data      (data_r),
        .op        (op_r),
        .serial_in (serial_in),
        .next_data (step_data_s),
        .out_bit   (step_out_s)
    );

    // Command FSM, remaining-count, data and serial-out registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            op_r     <= OP_NOP;
            count_r  <= '0;
            data_r   <= '0;
            serial_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_r <= cmd_op;
                        if (cmd_op == OP_LOAD) begin
                            data_r <= load_data;
                        end else begin
                            data_r <= data_r;
                        end
                        // Zero-length shifts complete like a NOP.
                        if (is_shift_op(cmd_op) && (cmd_amt != '0)) begin
                            state_r <= ST_SHIFT;
                            count_r <= cmd_amt;
                            done_r  <= 1'b0;
                        end else begin
                            state_r <= ST_DONE;
                            done_r  <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    data_r   <= step_data_s;
                    serial_r <= step_out_s;
                    count_r  <= count_r - AMT_W'(1);
                    if (count_r == AMT_W'(1)) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= ST_SHIFT;
                        done_r  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = (state_r == ST_IDLE);
    assign busy       = !cmd_ready;
    assign done       = done_r;
    assign data_out   = data_r;
    assign serial_out = serial_r;

endmodule

// File: doc/universal_shift_register.md
# universal_shift_register

Parametrised N-bit universal shift register: the command-driven successor to the basic left/right shifter. It accepts one command at a time through a valid/ready handshake and supports parallel load, logical and arithmetic shifts, and rotates by a programmable amount. Shifting advances one bit per clock, with serial input and output. It sits between datapath producers and serialising consumers (UART/SPI-style framers, bit-serial arithmetic), and reports completion with a one-cycle done pulse.

## Interface
- N, 8, register width; N >= 2
- AMT_W, $clog2(N), width of shift amount (derived; not overridden)
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command (high only in IDLE)
- cmd_op  in  3  0 NOP, 1 LOAD, 2 LSL, 3 LSR, 4 ASR, 5 ROL, 6 ROR, 7 reserved (treated as NOP)
- cmd_amt  in  AMT_W  shift count 0..N-1; ignored for LOAD/NOP
- load_data  in  N  parallel load value
- serial_in  in  1  fill bit for LSL/LSR, sampled on every shift edge
- data_out  out  N  register contents
- serial_out  out  1  last bit shifted or rotated out
- busy  out  1  high in SHIFT and DONE
- done  out  1  one-cycle pulse when the command completes

## Operation
- FSM states: IDLE, SHIFT, DONE.
- Accept: a command is accepted on the rising edge where cmd_valid && cmd_ready; op and amt are latched at that edge.
- IDLE -> SHIFT when an accepted shift op has amt > 0; the remaining count is loaded with amt.
- IDLE -> DONE for LOAD, NOP, reserved ops, or any shift with amt = 0.
- LOAD: data_out <= load_data on the accept edge; serial_out is unchanged.
- SHIFT: each edge applies one 1-bit step and decrements the count; when the count reaches 1, the next state is DONE.
- One-bit step semantics:
  - LSL: data <= {data[N-2:0], serial_in}; serial_out <= data[N-1].
  - LSR: data <= {serial_in, data[N-1:1]}; serial_out <= data[0].
  - ASR: data <= {data[N-1], data[N-1:1]}; serial_out <= data[0].
  - ROL: data <= {data[N-2:0], data[N-1]}; serial_out <= data[N-1].
  - ROR: data <= {data[0], data[N-1:1]}; serial_out <= data[0].
- DONE lasts exactly one cycle with done = 1, then returns to IDLE.
- cmd_valid while busy is ignored (cmd_ready = 0); the command is not queued. The producer holds it until accepted.
- Reset (reset_n low, any time including mid-shift): state = IDLE, data_out = 0, serial_out = 0, busy = 0, done = 0, count = 0. An in-flight command is discarded.

## Timing
- Accept on edge k. For amt = A > 0, shift edges are k+1..k+A, and done is high in the cycle after edge k+A.
- A back-to-back command can be accepted no earlier than edge k+A+2.
- LOAD, NOP, or A = 0: done is high in the cycle after edge k; the next accept is at k+2.
- cmd_ready = (state == IDLE), driven combinationally from state. busy = !cmd_ready.
- data_out and serial_out are registered; their value after edge k+A is final when done is seen.

## Structure
- Package usr_pkg holds:
  - op encodings as localparams OP_NOP..OP_ROR
  - the state encoding for IDLE/SHIFT/DONE
- Sub-module usr_shift_step: purely combinational 1-bit step, parameterised by N.
  - Inputs: data, op, serial_in.
  - Outputs: next data, out bit.
  - The top level holds the FSM, counter and registers.

## Test plan
- Reset, then LOAD 0xAA -> data_out = 0xAA after the accept edge; done pulses one cycle later; cmd_ready returns high.
- From 0xAA: LSR amt 3 with serial_in = 0 -> data_out = 0x15, serial_out = 0, done in the cycle after the 3rd shift edge, busy high for 4 cycles.
- ASR amt 2 from 0x80 -> 0xE0. LSL amt 4 from 0x0F with serial_in = 1 -> 0xFF, serial_out = 0.
- ROL amt 3 from 0x81 -> 0x0C. ROR amt 7 from 0x01 -> 0x02. Shift with amt 0 -> data unchanged, done in the next cycle.
- Issue LSR amt 7, pulse cmd_valid with LOAD 0x55 while busy -> the LOAD is ignored and the shift completes normally.
- Drop reset_n after the 3rd shift of LSR amt 7 -> data_out = 0, busy = 0 and done = 0 immediately, with no done pulse. Then LOAD 0x3C -> 0x3C.
